experiment_emulator: RTL

//  Plant-side emulator of the experiment set-up: answers the sequencing FSM's detonation_signal and

---
 rtl/experiment_emulator.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/experiment_emulator.sv
// Plant-side emulator of the experiment set-up: answers the sequencing FSM's detonation and
// trigger lines with frame-grabber, wire, phase-reference and detector-ready responses.
module experiment_emulator #(
    parameter int CNT_W        = 32,
    parameter int PHASE_PERIOD = 140,
    parameter int PHASE_HIGH   = 20,
    parameter int FG_DELAY     = 50,
    parameter int FG_LEN       = 10,
    parameter int WIRE_DELAY   = 100,
    parameter int WIRE_LEN     = 10,
    parameter int BUSY_DELAY   = 5,
    parameter int BUSY_LEN     = 1000
) (
    input  logic             clock,
    input  logic             reset_signal,
    input  logic             enable,
    input  logic             start_in,
    input  logic             detonation_in,
    input  logic             trigger_in,
    output logic             fg_signal,
    output logic             wire_signal,
    output logic             phase_signal,
    output logic             detector_ready,
    output logic             fault,
    output logic [15:0]      trigger_count,
    output logic [CNT_W-1:0] phase_at_trigger,
    output logic [3:0]       emu_state
);
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FG_DLY     = 4'd1,
        ST_FG_PULSE   = 4'd2,
        ST_WAIT_DET   = 4'd3,
        ST_WIRE_DLY   = 4'd4,
        ST_WIRE_PULSE = 4'd5,
        ST_WAIT_TRIG  = 4'd6,
        ST_BUSY_DLY   = 4'd7,
        ST_BUSY       = 4'd8,
        ST_DONE       = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] PH_LAST     = CNT_W'(PHASE_PERIOD - 1);
    localparam logic [CNT_W-1:0] PH_HIGH     = CNT_W'(PHASE_HIGH);
    localparam logic [CNT_W-1:0] FG_DLY_END  = CNT_W'(FG_DELAY - 1);
    localparam logic [CNT_W-1:0] FG_LEN_END  = CNT_W'(FG_LEN - 1);
    localparam logic [CNT_W-1:0] WR_DLY_END  = CNT_W'(WIRE_DELAY - 1);
    localparam logic [CNT_W-1:0] WR_LEN_END  = CNT_W'(WIRE_LEN - 1);
    localparam logic [CNT_W-1:0] BSY_DLY_END = CNT_W'(BUSY_DELAY - 1);
    localparam logic [CNT_W-1:0] BSY_LEN_END = CNT_W'(BUSY_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam bit               BUSY_HOLD   = (BUSY_LEN == 0);

    // bit 0 start, bit 1 detonation, bit 2 trigger
    logic [2:0]       s1_r, s2_r, rise_s;
    logic [CNT_W-1:0] pcnt_r, pcnt_nxt_s;
    logic             phase_r;
    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
    logic             fg_r, fg_s, wire_r, wire_s, ready_r, ready_s, fault_r, fault_s;
    logic [15:0]      tcnt_r, tcnt_s;
    logic [CNT_W-1:0] pat_r, pat_s;

    assign rise_s     = s1_r & ~s2_r;
    assign pcnt_nxt_s = (pcnt_r == PH_LAST) ? CNT_ZERO : (pcnt_r + CNT_ONE);
    assign cnt_inc_s  = cnt_r + CNT_ONE;

    // Two-flop input sampling chain feeding the rise detectors
    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            s1_r <= 3'b000;
            s2_r <= 3'b000;
        end else begin
            s1_r <= {trigger_in, detonation_in, start_in};
            s2_r <= s1_r;
        end
    end

    // Free-running phase reference, parked at zero while the emulator is disabled
    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            pcnt_r  <= CNT_ZERO;
            phase_r <= 1'b0;
        end else if (!enable) begin
            pcnt_r  <= CNT_ZERO;
            phase_r <= 1'b0;
        end else begin
            pcnt_r  <= pcnt_nxt_s;
            phase_r <= (pcnt_nxt_s < PH_HIGH);
        end
    end

    // Sequencer state and response registers
    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            fg_r    <= 1'b0;
            wire_r  <= 1'b0;
            ready_r <= 1'b1;
            fault_r <= 1'b0;
            tcnt_r  <= 16'd0;
            pat_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            fg_r    <= fg_s;
            wire_r  <= wire_s;
            ready_r <= ready_s;
            fault_r <= fault_s;
            tcnt_r  <= tcnt_s;
            pat_r   <= pat_s;
        end
    end

    // Next-state logic; stray detonation/trigger rises are judged against the current state
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        fg_s    = fg_r;
        wire_s  = wire_r;
        ready_s = ready_r;
        fault_s = fault_r;
        tcnt_s  = tcnt_r;
        pat_s   = pat_r;
        if (enable) begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s[0]) begin
                        state_s = ST_FG_DLY;
                        cnt_s   = CNT_ZERO;
                        fault_s = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FG_DLY: begin
                    if (cnt_r == FG_DLY_END) begin
                        state_s = ST_FG_PULSE;
                        fg_s    = 1'b1;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_FG_PULSE: begin
                    if (cnt_r == FG_LEN_END) begin
                        state_s = ST_WAIT_DET;
                        fg_s    = 1'b0;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_WAIT_DET: begin
                    if (rise_s[1]) begin
                        state_s = ST_WIRE_DLY;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_WAIT_DET;
                    end
                end
                ST_WIRE_DLY: begin
                    if (cnt_r == WR_DLY_END) begin
                        state_s = ST_WIRE_PULSE;
                        wire_s  = 1'b1;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_WIRE_PULSE: begin
                    if (cnt_r == WR_LEN_END) begin
                        state_s = ST_WAIT_TRIG;
                        wire_s  = 1'b0;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (rise_s[2]) begin
                        state_s = ST_BUSY_DLY;
                        cnt_s   = CNT_ZERO;
                        tcnt_s  = tcnt_r + 16'd1;
                        pat_s   = pcnt_r;
                    end else begin
                        state_s = ST_WAIT_TRIG;
                    end
                end
                ST_BUSY_DLY: begin
                    if (cnt_r == BSY_DLY_END) begin
                        state_s = ST_BUSY;
                        ready_s = 1'b0;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_BUSY: begin
                    if (BUSY_HOLD) begin
                        if (!s2_r[0]) begin
                            state_s = ST_IDLE;
                            ready_s = 1'b1;
                        end else begin
                            state_s = ST_BUSY;
                        end
                    end else if (cnt_r == BSY_LEN_END) begin
                        state_s = ST_DONE;
                        ready_s = 1'b1;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_DONE: begin
                    if (!s2_r[0]) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                    fg_s    = 1'b0;
                    wire_s  = 1'b0;
                    ready_s = 1'b1;
                end
            endcase
            fault_s = fault_s
                    | (rise_s[1] & (state_r != ST_WAIT_DET))
                    | (rise_s[2] & (state_r != ST_WAIT_TRIG));
        end else begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
            fg_s    = 1'b0;
            wire_s  = 1'b0;
            ready_s = 1'b1;
        end
    end

    assign fg_signal        = fg_r;
    assign wire_signal      = wire_r;
    assign phase_signal     = phase_r;
    assign detector_ready   = ready_r;
    assign fault            = fault_r;
    assign trigger_count    = tcnt_r;
    assign phase_at_trigger = pat_r;
    assign emu_state        = state_r;

endmodule
